fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch sequencer directly upstream of the instruction register. Holds the program counter and fetches one 16-bit instruction word per cycle of operation from memory via a req/ack handshake. Drives the IR data input and its active-low load strobe, then holds until the execute stage reports completion. Applies sequential increment, branch or halt to the PC.

Parameters:
ADDR_WIDTH, 16, width of PC and memory address.
RESET_VECTOR, 16'h0000, PC value after reset.
TIMEOUT_CYCLES, 15, maximum memory-wait cycles before fault; used only with FETCH_TIMEOUT_EN.

Ports:
clock  input  1  system clock, rising edge.
notReset  input  1  asynchronous active-low reset.
memAddr  output  ADDR_WIDTH  fetch address; always equals PC.
memReq  output  1  read request, level, registered.
memAck  input  1  memory data valid, sampled on rising edge while memReq=1.
memData  input  16  instruction word from memory.
irData  output  16  latched instruction word; drives IR data input.
irNotLoad  output  1  active-low IR load strobe, registered.
instrValid  output  1  IR contents valid for decode/execute.
execDone  input  1  execute stage finished current instruction; sampled only while instrValid=1.
branchEn  input  1  take branch; sampled with execDone.
branchAddr  input  ADDR_WIDTH  branch target.
halt  input  1  stop after current instruction; sampled with execDone.
halted  output  1  fetch stopped.
fault  output  1  memory timeout fault (0 when feature compiled out).

Behaviour:
- Reset (notReset=0, asynchronous, any state): PC=RESET_VECTOR, state=FETCH, memReq=0, irNotLoad=1, instrValid=0, halted=0, fault=0, irData=16'h0000.
- States: FETCH, LOAD, EXEC, HALTED.
- FETCH: memReq=1 from first clock edge after reset release (or entry into FETCH). On edge with memReq=1 and memAck=1: irData<=memData; memReq<=0; irNotLoad<=0; go LOAD. memAck while memReq=0 ignored.
- LOAD: irNotLoad=0 for exactly one cycle; IR captures irData on the closing edge. On that edge: irNotLoad<=1, instrValid<=1, PC<=PC+1 (mod 2^ADDR_WIDTH; 16'hFFFF wraps to 16'h0000); go EXEC.
- EXEC: instrValid=1; wait indefinitely for execDone. On edge with execDone=1: instrValid<=0; if branchEn, PC<=branchAddr, else PC unchanged (already incremented); if halt, go HALTED with halted<=1; else go FETCH, memReq<=1.
- branchEn and halt together: PC<=branchAddr, then HALTED.
- HALTED: all strobes inactive, PC frozen; exit only via reset.
- Minimum instruction period: 3 cycles (FETCH with immediate ack, LOAD, EXEC with immediate execDone).
- irData stable from LOAD entry until the next accepted memAck.
- Reset mid-fetch: memReq drops immediately (asynchronous); late memAck after release ignored until memReq reasserts.

Optional Feature:
FETCH_TIMEOUT_EN: compiled in, a wait counter clears on FETCH entry and increments each cycle memReq=1 without memAck. When it reaches TIMEOUT_CYCLES without ack: memReq<=0, fault<=1, halted<=1, go HALTED. memAck on the same edge as the limit wins (normal fetch). Compiled out: no counter, FETCH waits forever, fault tied 0.

Test Plan:
- Reset release, memAck tied 1, memData=16'hF0F0, execDone pulsed on first EXEC cycle -> memAddr=0000, irNotLoad low exactly one cycle with irData=F0F0, instrValid next cycle, next fetch at memAddr=0001, 3-cycle period.
- memAck delayed 4 cycles -> memReq held 5 cycles, no irNotLoad pulse before ack, memAddr stable.
- EXEC with execDone, branchEn=1, branchAddr=16'h1234 -> next memAddr=1234; repeat with RESET_VECTOR=16'hFFFF and no branch -> next memAddr=0000 (wrap).
- execDone with halt=1 and branchEn=1, branchAddr=16'h0040 -> halted=1, memReq stays 0, memAddr=0040; notReset pulse -> memAddr=RESET_VECTOR, fetch restarts.
- notReset asserted mid-FETCH with memReq=1 -> memReq, irNotLoad=1, instrValid=0 immediately without clock edge; memAck during reset ignored.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, memAck never -> fault=1, halted=1 after 15 cycles of memReq. memAck exactly on the limit edge -> normal LOAD, fault=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, memory req/ack fetch, IR load strobe, execute wait.
// Optional memory-wait timeout fault is compiled in with `define FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = '0,
  parameter int                    TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  notReset,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memReq,
  input  logic                  memAck,
  input  logic [15:0]           memData,
  output logic [15:0]           irData,
  output logic                  irNotLoad,
  output logic                  instrValid,
  input  logic                  execDone,
  input  logic                  branchEn,
  input  logic [ADDR_WIDTH-1:0] branchAddr,
  input  logic                  halt,
  output logic                  halted,
  output logic                  fault,
  output logic [1:0]            state_dbg
);

  // Handshake: a fetch completes on a rising edge where memReq=1 and memAck=1;
  // an instruction retires on a rising edge where instrValid=1 and execDone=1.
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_LOAD   = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    mem_req_q, mem_req_d;
  logic [15:0]             ir_data_q, ir_data_d;
  logic                    ir_not_load_q, ir_not_load_d;
  logic                    instr_valid_q, instr_valid_d;
  logic                    halted_q, halted_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]        wait_cnt_q, wait_cnt_d;
  logic                    fault_q, fault_d;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_req_d     = mem_req_q;
    ir_data_d     = ir_data_q;
    ir_not_load_d = ir_not_load_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
`ifdef FETCH_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    fault_d       = fault_q;
`endif
    case (state_q)
      S_FETCH: begin
        if (mem_req_q && memAck) begin
          ir_data_d     = memData;
          mem_req_d     = 1'b0;
          ir_not_load_d = 1'b0;
          state_d       = S_LOAD;
`ifdef FETCH_TIMEOUT_EN
        end else if (mem_req_q && (wait_cnt_q == CNT_LAST)) begin
          // Ack on the limit edge is taken by the branch above.
          mem_req_d = 1'b0;
          fault_d   = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_HALTED;
        end else begin
          mem_req_d = 1'b1;
          if (mem_req_q) wait_cnt_d = wait_cnt_q + CNT_W'(1);
`else
        end else begin
          mem_req_d = 1'b1;
`endif
        end
      end
      S_LOAD: begin
        ir_not_load_d = 1'b1;
        instr_valid_d = 1'b1;
        pc_d          = pc_q + ADDR_WIDTH'(1);
        state_d       = S_EXEC;
      end
      S_EXEC: begin
        if (execDone) begin
          instr_valid_d = 1'b0;
          if (branchEn) pc_d = branchAddr;
          if (halt) begin
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            mem_req_d = 1'b1;
            state_d   = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
          end
        end
      end
      default: begin
        mem_req_d     = 1'b0;
        ir_not_load_d = 1'b1;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_VECTOR;
      mem_req_q     <= 1'b0;
      ir_data_q     <= 16'h0000;
      ir_not_load_q <= 1'b1;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_req_q     <= mem_req_d;
      ir_data_q     <= ir_data_d;
      ir_not_load_q <= ir_not_load_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      fault_q       <= fault_d;
`endif
    end
  end

  assign memAddr    = pc_q;
  assign memReq     = mem_req_q;
  assign irData     = ir_data_q;
  assign irNotLoad  = ir_not_load_q;
  assign instrValid = instr_valid_q;
  assign halted     = halted_q;
  assign state_dbg  = state_q;
`ifdef FETCH_TIMEOUT_EN
  assign fault      = fault_q;
`else
  assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, randomized instruction stream against a PC model,
// and hand-written reset / halt / timeout sequences.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        notReset;
  logic [15:0] memAddr;
  logic        memReq;
  logic        memAck;
  logic [15:0] memData;
  logic [15:0] irData;
  logic        irNotLoad;
  logic        instrValid;
  logic        execDone;
  logic        branchEn;
  logic [15:0] branchAddr;
  logic        halt;
  logic        halted;
  logic        fault;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [15:0] model_pc;
  logic [31:0] exp_q[$];

  fetch_unit #(.ADDR_WIDTH(16), .RESET_VECTOR(16'h0000), .TIMEOUT_CYCLES(15)) dut (
    .clock(clock), .notReset(notReset), .memAddr(memAddr), .memReq(memReq),
    .memAck(memAck), .memData(memData), .irData(irData), .irNotLoad(irNotLoad),
    .instrValid(instrValid), .execDone(execDone), .branchEn(branchEn),
    .branchAddr(branchAddr), .halt(halt), .halted(halted), .fault(fault),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every IR load must match the next expected {address, word}
  always @(negedge clock) begin
    if (notReset === 1'b1 && irNotLoad === 1'b0) begin
      if (exp_q.size() == 0) check("unexpected_load", {memAddr, irData}, 32'hxxxx_xxxx);
      else check("fetch_word", {memAddr, irData}, exp_q.pop_front());
    end
  end

  task automatic do_reset();
    notReset = 1'b0; memAck = 1'b0; execDone = 1'b0; branchEn = 1'b0; halt = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_memReq", memReq, 0);
    check("rst_irNotLoad", irNotLoad, 1);
    check("rst_instrValid", instrValid, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_irData", irData, 16'h0000);
    check("rst_memAddr", memAddr, 16'h0000);
    notReset = 1'b1;
    model_pc = 16'h0000;
    exp_q.delete();
  endtask

  task automatic wait_req();
    int n = 0;
    while (memReq !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("req_wait", memReq, 1);
  endtask

  // driver: one full instruction with given ack and execute latencies
  task automatic run_instr(input logic [15:0] data, input int ack_dly, input int exec_dly,
                           input logic br, input logic [15:0] ba, input logic hl);
    logic [15:0] addr, addr1;
    int start;
    memAck = 1'b0;
    wait_req();
    addr = memAddr; addr1 = memAddr + 16'd1; start = cyc;
    exp_q.push_back({model_pc, data});
    memData = data;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clock);
      check("req_held", memReq, 1);
      check("no_early_load", irNotLoad, 1);
      check("addr_stable", memAddr, addr);
    end
    memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0; memData = 16'($urandom);
    check("load_strobe", irNotLoad, 0);
    check("req_drop", memReq, 0);
    @(negedge clock);
    check("load_one_cycle", irNotLoad, 1);
    check("instr_valid", instrValid, 1);
    check("pc_inc", memAddr, addr1);
    for (int i = 0; i < exec_dly; i++) begin
      @(negedge clock);
      check("exec_wait", instrValid, 1);
      check("ir_stable", irData, data);
    end
    execDone = 1'b1; branchEn = br; branchAddr = ba; halt = hl;
    @(negedge clock);
    execDone = 1'b0; branchEn = 1'b0; halt = 1'b0; branchAddr = 16'($urandom);
    model_pc = br ? ba : 16'(model_pc + 16'd1);
    check("instr_done", instrValid, 0);
    check("next_addr", memAddr, model_pc);
    check("halted_flag", halted, hl);
    check("req_next", memReq, !hl);
    if (!hl) check("period", cyc - start, ack_dly + exec_dly + 3);
  endtask

  typedef struct {
    logic [15:0] data;
    int          ack_dly;
    int          exec_dly;
    logic        br;
    logic [15:0] ba;
    logic [15:0] exp_next;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'hF0F0, 0, 0, 1'b0, 16'h0000, 16'h0001};
    vecs[1] = '{16'h1111, 4, 0, 1'b0, 16'h0000, 16'h0002};
    vecs[2] = '{16'h2222, 0, 2, 1'b1, 16'h1234, 16'h1234};
    vecs[3] = '{16'h3333, 1, 0, 1'b1, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{16'h4444, 0, 0, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{16'h5555, 0, 1, 1'b0, 16'h0000, 16'h0001};
    memData = 16'h0000; branchAddr = 16'h0000;
    do_reset();

    for (int i = 0; i < 6; i++) begin
      run_instr(vecs[i].data, vecs[i].ack_dly, vecs[i].exec_dly, vecs[i].br, vecs[i].ba, 1'b0);
      check("tbl_next", memAddr, vecs[i].exp_next);
    end

    for (int i = 0; i < 40; i++) begin
      logic br;
      br = ($urandom_range(0, 3) == 0);
      run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), br,
                16'($urandom), 1'b0);
    end

    // halt together with branch, then memAck ignored while halted
    run_instr(16'hBEEF, 0, 0, 1'b1, 16'h0040, 1'b1);
    memAck = 1'b1;
    repeat (5) @(negedge clock);
    check("halt_req", memReq, 0);
    check("halt_addr", memAddr, 16'h0040);
    check("halt_strobe", irNotLoad, 1);
    check("halt_flag", halted, 1);
    memAck = 1'b0;

    // reset leaves halt; fetch restarts at the reset vector
    do_reset();
    run_instr(16'h7777, 0, 0, 1'b0, 16'h0000, 1'b0);

    // asynchronous reset during an outstanding fetch, ack held across release
    memAck = 1'b0;
    wait_req();
    #2 notReset = 1'b0; memAck = 1'b1;
    #1;
    check("async_req", memReq, 0);
    check("async_strobe", irNotLoad, 1);
    check("async_valid", instrValid, 0);
    check("async_addr", memAddr, 16'h0000);
    repeat (2) @(negedge clock);
    check("rst_ack_ignored", irNotLoad, 1);
    notReset = 1'b1; model_pc = 16'h0000; exp_q.delete();
    @(negedge clock);
    check("late_ack_ignored", irNotLoad, 1);
    check("late_ack_req", memReq, 1);
    run_instr(16'hA5A5, 0, 0, 1'b0, 16'h0000, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    memAck = 1'b0;
    wait_req();
    repeat (14) @(negedge clock);
    check("to_before_fault", fault, 0);
    check("to_before_req", memReq, 1);
    @(negedge clock);
    check("to_fault", fault, 1);
    check("to_halted", halted, 1);
    check("to_req", memReq, 0);
    do_reset();
    wait_req();
    repeat (14) @(negedge clock);
    exp_q.push_back({model_pc, 16'hC3C3});
    memData = 16'hC3C3; memAck = 1'b1;
    @(negedge clock);
    memAck = 1'b0;
    check("limit_ack_load", irNotLoad, 0);
    check("limit_ack_fault", fault, 0);
`else
    memAck = 1'b0;
    wait_req();
    repeat (20) @(negedge clock);
    check("no_timeout_req", memReq, 1);
    check("no_timeout_fault", fault, 0);
    check("no_timeout_halted", halted, 0);
`endif
    @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
